// File: rtl/fizzbuzz_multi_if.sv
// -----------------------------------------------------------------------------
// fizzbuzz_multi_if
// Bundles the control inputs and status outputs of fizzbuzz_multi.
//   master : drives en / clr / limit, observes the status outputs
//   slave  : the counter itself (receives controls, drives status)
// Signals:
//   en      advance the count when high
//   clr     synchronous restart to count 0 (no wrap pulse)
//   limit   runtime sequence length (0 or > MAX_CYCLES selects MAX_CYCLES)
//   count   current count value
//   hit     per-channel divisibility flags
//   all_hit AND of hit
//   any_hit OR of hit
//   wrap    one-cycle pulse on the first cycle back at count 0 after a wrap
//   all_cnt number of landings on an all_hit count (0 when stats are off)
// -----------------------------------------------------------------------------
interface fizzbuzz_multi_if #(
    parameter int NUM_DIV = 4,
    parameter int CW      = 7
);
    logic               en;
    logic               clr;
    logic [CW-1:0]      limit;
    logic [CW-1:0]      count;
    logic [NUM_DIV-1:0] hit;
    logic               all_hit;
    logic               any_hit;
    logic               wrap;
    logic [15:0]        all_cnt;

    modport master (
        output en, clr, limit,
        input  count, hit, all_hit, any_hit, wrap, all_cnt
    );

    modport slave (
        input  en, clr, limit,
        output count, hit, all_hit, any_hit, wrap, all_cnt
    );
endinterface

// File: rtl/fizzbuzz_multi.sv
// -----------------------------------------------------------------------------
// fizzbuzz_multi
// Enable-gated counter of programmable length that flags, every cycle, which
// of NUM_DIV compile-time divisors evenly divide the current count.
// Divisibility is tracked by one residue counter per channel, so no divider
// sits in any timing path.
//
// Ports:
//   i_clk     clock, all logic on the rising edge
//   i_resetn  synchronous, active-low reset
//   bus       fizzbuzz_multi_if.slave (en, clr, limit in; count, hit,
//             all_hit, any_hit, wrap, all_cnt out)
//
// Optional feature macro: FIZZBUZZ_MULTI_STATS_EN
//   defined     -> all_cnt counts landings on an all_hit count (saturating)
//   not defined -> all_cnt tied to 16'h0000, no counter built
// -----------------------------------------------------------------------------
module fizzbuzz_multi #(
    parameter int                       NUM_DIV    = 4,
    parameter int                       DIV_W      = 8,
    parameter logic [NUM_DIV*DIV_W-1:0] DIVISORS   = 32'h07050302,
    parameter int                       MAX_CYCLES = 100,
    parameter int                       CW         = $clog2(MAX_CYCLES)
) (
    input  logic                 i_clk,
    input  logic                 i_resetn,
    fizzbuzz_multi_if.slave      bus
);

    localparam logic [CW-1:0] LAST_MAX = CW'(MAX_CYCLES - 1);

    if (NUM_DIV < 1 || NUM_DIV > 16) begin : g_bad_num
        $error("fizzbuzz_multi: NUM_DIV must be 1..16");
    end
    if (MAX_CYCLES < 2) begin : g_bad_max
        $error("fizzbuzz_multi: MAX_CYCLES must be >= 2");
    end

    // State
    logic [CW-1:0]                  r_cnt;
    logic [NUM_DIV-1:0][DIV_W-1:0]  r_res;
    logic                           r_wrap;

    // Next state / helpers
    logic [CW-1:0]                  w_cnt_nxt;
    logic [NUM_DIV-1:0][DIV_W-1:0]  w_res_nxt;
    logic                           w_wrap_nxt;
    logic [NUM_DIV-1:0][DIV_W-1:0]  w_dm1;
    logic                           w_use_max;
    logic [CW-1:0]                  w_last;
    logic [NUM_DIV-1:0]             w_hit;
    logic                           w_nxt_all0;

    // Per-channel divisor minus one (residue roll-over point) and hit flags.
    for (genvar g = 0; g < NUM_DIV; g++) begin : g_ch
        if (DIVISORS[g*DIV_W +: DIV_W] == '0) begin : g_bad_div
            $error("fizzbuzz_multi: divisor field %0d is zero", g);
        end
        assign w_dm1[g] = DIVISORS[g*DIV_W +: DIV_W] - DIV_W'(1);
        assign w_hit[g] = (r_res[g] == '0);
    end

    // Effective last count L-1; limit is re-evaluated every cycle.
    assign w_use_max = (bus.limit == '0) ||
                       ({1'b0, bus.limit} > (CW+1)'(MAX_CYCLES));
    assign w_last    = w_use_max ? LAST_MAX : (bus.limit - CW'(1));

    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_res_nxt  = r_res;
        w_wrap_nxt = 1'b0;
        if (bus.clr) begin
            w_cnt_nxt = '0;
            w_res_nxt = '0;
        end else if (bus.en) begin
            // >= rather than == so that lowering limit below the current
            // count wraps immediately instead of running on to 2^CW.
            if (r_cnt >= w_last) begin
                w_cnt_nxt  = '0;
                w_res_nxt  = '0;
                w_wrap_nxt = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + CW'(1);
                for (int i = 0; i < NUM_DIV; i++) begin
                    w_res_nxt[i] = (r_res[i] == w_dm1[i]) ? '0
                                                          : r_res[i] + DIV_W'(1);
                end
            end
        end
    end

    assign w_nxt_all0 = (w_res_nxt == '0);

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_cnt  <= '0;
            r_res  <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_res  <= w_res_nxt;
            r_wrap <= w_wrap_nxt;
        end
    end

`ifdef FIZZBUZZ_MULTI_STATS_EN
    logic [15:0] r_all_cnt;

    // Counts enabled edges that land on a count where every channel hits.
    always_ff @(posedge i_clk) begin
        if (!i_resetn || bus.clr) begin
            r_all_cnt <= '0;
        end else if (bus.en && w_nxt_all0 && (r_all_cnt != 16'hFFFF)) begin
            r_all_cnt <= r_all_cnt + 16'd1;
        end
    end

    assign bus.all_cnt = r_all_cnt;
`else
    logic w_unused_stats;
    assign w_unused_stats = w_nxt_all0;
    assign bus.all_cnt    = 16'h0000;
`endif

    assign bus.count   = r_cnt;
    assign bus.hit     = w_hit;
    assign bus.all_hit = &w_hit;
    assign bus.any_hit = |w_hit;
    assign bus.wrap    = r_wrap;

endmodule

// File: tb/tb_fizzbuzz_multi.sv
// -----------------------------------------------------------------------------
// tb_fizzbuzz_multi
// Directed bench for fizzbuzz_multi with default parameters (divisors 2,3,5,7,
// MAX_CYCLES 100). A small reference model tracks count / wrap / all_cnt and
// is cross-checked against hand-computed points.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fizzbuzz_multi;

    logic clk;
    logic resetn;

    int n_chk  = 0;
    int n_fail = 0;

    int m_cnt;
    int m_wrap;
    int m_acnt;

    fizzbuzz_multi_if #(.NUM_DIV(4), .CW(7)) bus ();

    fizzbuzz_multi dut (
        .i_clk    (clk),
        .i_resetn (resetn),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_hit(input int c);
        return {(c % 7) == 0, (c % 5) == 0, (c % 3) == 0, (c % 2) == 0};
    endfunction

    // One clock with the currently driven inputs; model updated, then all
    // outputs compared #1 after the edge.
    task automatic step(input string tag);
        int L;
        logic [3:0] h;
        L = (bus.limit == 0 || bus.limit > 100) ? 100 : int'(bus.limit);
        if (!resetn || bus.clr) begin
            m_cnt  = 0;
            m_wrap = 0;
            m_acnt = 0;
        end else if (bus.en) begin
            if (m_cnt >= L - 1) begin
                m_cnt  = 0;
                m_wrap = 1;
                if (m_acnt < 65535) m_acnt++;
            end else begin
                m_cnt++;
                m_wrap = 0;
            end
        end else begin
            m_wrap = 0;
        end
        @(posedge clk);
        #1;
        h = exp_hit(m_cnt);
        chk_eq({tag, "_count"}, 32'(bus.count), 32'(m_cnt));
        chk_eq({tag, "_hit"}, 32'(bus.hit), 32'(h));
        chk_eq({tag, "_all_hit"}, 32'(bus.all_hit), 32'(&h));
        chk_eq({tag, "_any_hit"}, 32'(bus.any_hit), 32'(|h));
        chk_eq({tag, "_wrap"}, 32'(bus.wrap), 32'(m_wrap));
`ifdef FIZZBUZZ_MULTI_STATS_EN
        chk_eq({tag, "_all_cnt"}, 32'(bus.all_cnt), 32'(m_acnt));
`else
        chk_eq({tag, "_all_cnt"}, 32'(bus.all_cnt), 32'd0);
`endif
    endtask

    task automatic run_to(input int target, input string tag);
        for (int k = 0; k < 200 && int'(bus.count) != target; k++) step(tag);
        chk_eq({tag, "_reached"}, 32'(bus.count), 32'(target));
    endtask

    initial begin
        resetn    = 1'b0;
        bus.en    = 1'b0;
        bus.clr   = 1'b0;
        bus.limit = '0;
        m_cnt = 0; m_wrap = 0; m_acnt = 0;

        // Reset values
        step("rst0");
        step("rst1");
        chk_eq("rst_hit", 32'(bus.hit), 32'hF);
        resetn = 1'b1;
        step("idle");

        // Full pass with limit 0 (= 100)
        bus.en = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            step("pass");
            if (k == 6)  chk_eq("hand_hit6", 32'(bus.hit), 32'b0011);
            if (k == 99) chk_eq("hand_cnt99", 32'(bus.count), 32'd99);
        end
        chk_eq("hand_pass_cnt0", 32'(bus.count), 32'd0);
        chk_eq("hand_pass_wrap", 32'(bus.wrap), 32'd1);
`ifdef FIZZBUZZ_MULTI_STATS_EN
        chk_eq("hand_allcnt_pass", 32'(bus.all_cnt), 32'd1);
`else
        chk_eq("hand_allcnt_pass", 32'(bus.all_cnt), 32'd0);
`endif
        step("post_wrap");
        chk_eq("hand_wrap_drop", 32'(bus.wrap), 32'd0);

        // Limit 10 from count 4, then 3 from count 7
        run_to(4, "to4");
        bus.limit = 7'd10;
        step("l10_5");
        chk_eq("hand_hit5", 32'(bus.hit), 32'b0100);
        for (int k = 0; k < 24; k++) step("l10");
        run_to(7, "to7");
        bus.limit = 7'd3;
        step("l3");
        chk_eq("hand_l3_cnt", 32'(bus.count), 32'd0);
        chk_eq("hand_l3_wrap", 32'(bus.wrap), 32'd1);
        step("l3b");
        step("l3c");
        step("l3d");

        // Enable toggling around count 30
        bus.limit = '0;
        run_to(29, "to29");
        step("e1");
        bus.en = 1'b0;
        step("e0a");
        chk_eq("hand_hold_hit", 32'(bus.hit), 32'b0111);
        step("e0b");
        chk_eq("hand_hold_cnt", 32'(bus.count), 32'd30);
        bus.en = 1'b1;
        step("e1b");
        chk_eq("hand_resume", 32'(bus.count), 32'd31);

        // clr at 42 with en high
        run_to(42, "to42");
        bus.clr = 1'b1;
        step("clr");
        chk_eq("hand_clr_hit", 32'(bus.hit), 32'hF);
        bus.clr = 1'b0;
        step("after_clr");

        // resetn at 55
        run_to(55, "to55");
        resetn = 1'b0;
        step("rst55");
        chk_eq("hand_rst_cnt", 32'(bus.count), 32'd0);
        resetn = 1'b1;

        // limit 1: stuck at 0, wrap every enabled cycle
        bus.limit = 7'd1;
        for (int k = 0; k < 4; k++) step("l1");
        chk_eq("hand_l1_wrap", 32'(bus.wrap), 32'd1);
        bus.en = 1'b0;
        step("l1_hold");
        chk_eq("hand_l1_drop", 32'(bus.wrap), 32'd0);
        bus.en = 1'b1;
        step("l1_again");

        // limit 127 behaves as 100
        bus.limit = 7'd127;
        for (int k = 1; k <= 100; k++) begin
            step("l127");
            if (k == 99) chk_eq("hand_l127_99", 32'(bus.count), 32'd99);
        end
        chk_eq("hand_l127_wrap", 32'(bus.wrap), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
